// File: rtl/alu_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_queue_if
//   Bundles the command-producer handshake and the ALU issue bus of
//   alu_cmd_queue into one interface.
//   Signals:
//     i_flush, i_stall                  control from the surrounding pipeline
//     i_valid/o_ready, i_op, i_arg_A/B  producer command handshake
//     o_op, o_arg_A/B, o_issue          issued command towards the ALU
//     o_count, o_full, o_empty          occupancy status
//     o_issued_cnt                      issue counter (ALU_CMD_STATS_EN only)
//   Modports:
//     slave  - the queue itself
//     master - the environment driving the queue
// ---------------------------------------------------------------------------
interface alu_cmd_queue_if #(
  parameter int N     = 2,
  parameter int M     = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [N-1:0]  i_op;
  logic [M-1:0]  i_arg_A;
  logic [M-1:0]  i_arg_B;
  logic          i_stall;
  logic [N-1:0]  o_op;
  logic [M-1:0]  o_arg_A;
  logic [M-1:0]  o_arg_B;
  logic          o_issue;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;
`ifdef ALU_CMD_STATS_EN
  logic [15:0]   o_issued_cnt;
`endif

  modport slave (
    input  i_flush, i_valid, i_op, i_arg_A, i_arg_B, i_stall,
    output o_ready, o_op, o_arg_A, o_arg_B, o_issue, o_count, o_full, o_empty
`ifdef ALU_CMD_STATS_EN
    , output o_issued_cnt
`endif
  );

  modport master (
    output i_flush, i_valid, i_op, i_arg_A, i_arg_B, i_stall,
    input  o_ready, o_op, o_arg_A, o_arg_B, o_issue, o_count, o_full, o_empty
`ifdef ALU_CMD_STATS_EN
    , input o_issued_cnt
`endif
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// ---------------------------------------------------------------------------
// alu_cmd_queue
//   Command FIFO in front of the ALU. Accepts {op, A, B} via valid/ready and
//   issues at most one command per cycle into registered o_op/o_arg_* with a
//   registered o_issue strobe. i_stall holds the head; i_flush empties the
//   queue (priority over push and pop). No empty-queue bypass: a command is
//   issued no earlier than the edge after it was accepted.
//   Ports:
//     i_clk    clock, rising edge
//     i_reset  asynchronous reset, active low
//     bus      alu_cmd_queue_if.slave (handshake, issue bus, status)
//   Optional feature macro: ALU_CMD_STATS_EN adds bus.o_issued_cnt[15:0],
//   a wrapping count of issue edges, cleared by reset only.
// ---------------------------------------------------------------------------
module alu_cmd_queue #(
  parameter int N     = 2,
  parameter int M     = 4,
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  alu_cmd_queue_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [N-1:0] op;
    logic [M-1:0] arg_a;
    logic [M-1:0] arg_b;
  } cmd_t;

  cmd_t         mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  cmd_t          out_cmd;
  logic          issue;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Ready depends on fullness only, so a full queue never pushes even if a
  // pop happens on the same edge.
  assign push = bus.i_valid && !full && !bus.i_flush;
  assign pop  = !empty && !bus.i_stall && !bus.i_flush;

  // NOTE: storage has no reset; its contents are don't-care until written,
  // and keeping it out of the reset tree lets it map to plain RAM/flops.
  always_ff @(posedge i_clk) begin
    if (push) mem[tail] <= '{op: bus.i_op, arg_a: bus.i_arg_A, arg_b: bus.i_arg_B};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue registers: data holds between issues and across a flush.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      out_cmd <= '0;
      issue   <= 1'b0;
    end else begin
      issue <= pop;
      if (pop) out_cmd <= mem[head];
    end
  end

`ifdef ALU_CMD_STATS_EN
  logic [15:0] issued_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)  issued_cnt <= '0;
    else if (pop)  issued_cnt <= issued_cnt + 16'd1;
  end

  assign bus.o_issued_cnt = issued_cnt;
`endif

  assign bus.o_ready = !full;
  assign bus.o_op    = out_cmd.op;
  assign bus.o_arg_A = out_cmd.arg_a;
  assign bus.o_arg_B = out_cmd.arg_b;
  assign bus.o_issue = issue;
  assign bus.o_count = count;
  assign bus.o_full  = full;
  assign bus.o_empty = empty;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_queue
//   Self-checking bench for alu_cmd_queue. A reference queue holds the
//   commands expected to be inside the DUT; each accepted push appends to it
//   and each expected issue pops from it and is compared against o_op/o_arg_*.
// ---------------------------------------------------------------------------
module tb_alu_cmd_queue;
  localparam int N     = 2;
  localparam int M     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [N-1:0] op;
    logic [M-1:0] a;
    logic [M-1:0] b;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_cmd_queue_if #(.N(N), .M(M), .DEPTH(DEPTH)) bus ();

  alu_cmd_queue #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  cmd_t sb [$];
  logic exp_issue;
  cmd_t exp_out;
  int   exp_stats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check("count", 32'(bus.o_count), 32'(sb.size()));
    check("ready", 32'(bus.o_ready), 32'(sb.size() < DEPTH));
    check("full",  32'(bus.o_full),  32'(sb.size() == DEPTH));
    check("empty", 32'(bus.o_empty), 32'(sb.size() == 0));
  endtask

  // Advance one clock with the currently driven inputs, updating the model
  // first and comparing the DUT shortly after the edge.
  task automatic tick();
    int   sz;
    cmd_t c;
    sz = sb.size();
    exp_issue = 1'b0;
    if (bus.i_flush) begin
      sb.delete();
    end else begin
      if (sz > 0 && !bus.i_stall) begin
        exp_out   = sb.pop_front();
        exp_issue = 1'b1;
        exp_stats = (exp_stats + 1) & 16'hFFFF;
      end
      if (bus.i_valid && sz < DEPTH) begin
        c = '{op: bus.i_op, a: bus.i_arg_A, b: bus.i_arg_B};
        sb.push_back(c);
      end
    end
    @(posedge clk);
    #1;
    check("issue", 32'(bus.o_issue), 32'(exp_issue));
    check("op",    32'(bus.o_op),    32'(exp_out.op));
    check("arg_a", 32'(bus.o_arg_A), 32'(exp_out.a));
    check("arg_b", 32'(bus.o_arg_B), 32'(exp_out.b));
    check_status();
`ifdef ALU_CMD_STATS_EN
    check("issued_cnt", 32'(bus.o_issued_cnt), 32'(exp_stats));
`endif
  endtask

  task automatic drive(input logic v, input logic [N-1:0] op,
                       input logic [M-1:0] a, input logic [M-1:0] b);
    bus.i_valid = v;
    bus.i_op    = op;
    bus.i_arg_A = a;
    bus.i_arg_B = b;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_issue = 1'b0;
    exp_out   = '0;
    exp_stats = 0;
    #2;
    check("rst_issue", 32'(bus.o_issue), 32'd0);
    check("rst_op",    32'({bus.o_op, bus.o_arg_A, bus.o_arg_B}), 32'd0);
    check_status();
`ifdef ALU_CMD_STATS_EN
    check("rst_issued_cnt", 32'(bus.o_issued_cnt), 32'd0);
`endif
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    drive(1'b0, '0, '0, '0);
    exp_issue = 1'b0;
    exp_out   = '0;
    exp_stats = 0;

    // Reset state
    #3;
    pulse_reset();

    // Two back-to-back commands, no stall
    drive(1'b1, 2'b00, 4'd3, 4'd1); tick();
    drive(1'b1, 2'b01, 4'd7, 4'd4); tick();
    drive(1'b0, '0, '0, '0);        tick();
    tick();
    tick();

    // Stall while filling; fifth valid ignored; then drain in order
    bus.i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i), 4'(i + 8), 4'(15 - i));
      tick();
    end
    check("full_after_fill",  32'(bus.o_full),  32'd1);
    check("ready_after_fill", 32'(bus.o_ready), 32'd0);
    drive(1'b0, '0, '0, '0);
    bus.i_stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("empty_after_drain", 32'(bus.o_empty), 32'd1);

    // Full queue with valid held: pop only, then push+pop together
    bus.i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(3 - i), 4'(i), 4'(i * 3));
      tick();
    end
    bus.i_stall = 1'b0;
    drive(1'b1, 2'b10, 4'hA, 4'h5); tick();
    check("count_pop_only", 32'(bus.o_count), 32'd3);
    drive(1'b1, 2'b11, 4'h6, 4'h9); tick();
    check("count_push_pop", 32'(bus.o_count), 32'd3);

    // Three entries held, flush with a simultaneous push
    bus.i_stall = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();
    bus.i_flush = 1'b1;
    drive(1'b1, 2'b01, 4'hF, 4'hE);
    tick();
    check("count_after_flush", 32'(bus.o_count), 32'd0);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    drive(1'b1, 2'b10, 4'hC, 4'h2); tick();
    drive(1'b0, '0, '0, '0);        tick();
    tick();

    // Issue counter across a flush, then a mid-stream async reset
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i), 4'(i), 4'(i + 1));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    tick();
    bus.i_flush = 1'b1; tick();
    bus.i_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'(i), 4'(i + 4), 4'(i + 2));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    tick();
`ifdef ALU_CMD_STATS_EN
    check("issued_cnt_7", 32'(bus.o_issued_cnt), 32'd7);
`endif
    bus.i_stall = 1'b1;
    drive(1'b1, 2'b11, 4'h1, 4'h2); tick();
    drive(1'b1, 2'b10, 4'h3, 4'h4); tick();
    bus.i_stall = 1'b0;
    tick();
    pulse_reset();
    drive(1'b0, '0, '0, '0);
    tick();
    tick();

    // Randomised traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      bus.i_stall = ($urandom_range(0, 3) == 0);
      bus.i_flush = ($urandom_range(0, 31) == 0);
      drive(1'($urandom_range(0, 1)), N'($urandom), M'($urandom), M'($urandom));
      tick();
    end
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < DEPTH + 1; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
